// File: rtl/quant_stream.sv
// quant_stream -- streaming 8x8-block coefficient quantizer.
//
// Takes one signed DCT coefficient per cycle in raster order (valid/ready),
// multiplies it by a per-position Q8 reciprocal scaled by a Q4.4 quality
// factor, shifts by FRAC and saturates to OW bits. Three register stages
// under a single global stall; latency 3, throughput 1/cycle.
//
// Optional build macro: QUANT_ROUND_EN
//   defined   -> final shift rounds half away from zero
//   undefined -> final shift floors (arithmetic shift)
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready = !stall
//   in_data  [DW-1:0]     signed coefficient
//   in_last               marks coefficient 63 of a block (resyncs index)
//   q_scale  [7:0]        quality factor Q4.4, sampled on the idx-0 handshake
//   out_valid/out_ready   output handshake
//   out_data [OW-1:0]     signed quantized coefficient
//   out_idx  [5:0]        raster position of out_data
//   out_last              out_idx == 63
//   out_sat               out_data was clamped
//   err_misalign          sticky: in_last disagreed with the internal index
`default_nettype none

module quant_stream #(
  parameter int DW   = 16,
  parameter int OW   = 16,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic [7:0]    q_scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [5:0]    out_idx,
  output logic          out_last,
  output logic          out_sat,
  output logic          err_misalign
);

  localparam int PW = DW + 13;  // full-precision product width
  localparam int RW = PW + 1;   // one guard bit so negation never overflows

  localparam logic signed [RW-1:0] OMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Q8 reciprocals, raster order (row = idx[5:3], col = idx[2:0])
  localparam logic [4:0] TBL [64] = '{
    5'd16, 5'd21, 5'd18, 5'd18, 5'd14, 5'd10, 5'd5,  5'd3,
    5'd23, 5'd21, 5'd19, 5'd15, 5'd11, 5'd7,  5'd4,  5'd2,
    5'd25, 5'd18, 5'd16, 5'd11, 5'd6,  5'd4,  5'd3,  5'd2,
    5'd16, 5'd13, 5'd10, 5'd8,  5'd4,  5'd4,  5'd2,  5'd2,
    5'd10, 5'd9,  5'd6,  5'd5,  5'd3,  5'd3,  5'd2,  5'd2,
    5'd6,  5'd4,  5'd4,  5'd2,  5'd2,  5'd2,  5'd2,  5'd2,
    5'd5,  5'd4,  5'd3,  5'd3,  5'd2,  5'd2,  5'd2,  5'd2,
    5'd4,  5'd4,  5'd4,  5'd4,  5'd3,  5'd2,  5'd2,  5'd2
  };

  // ---------------- control ----------------
  logic stall, hs, misalign;
  logic [5:0] idx_reg;
  logic [7:0] scale_reg;
  logic       err_reg;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign hs       = in_valid && in_ready;
  assign misalign = (in_last && idx_reg != 6'd63) || (!in_last && idx_reg == 6'd63);

  // ---------------- S1 combinational: reciprocal ----------------
  logic [7:0]  q_eff, scale_use;
  logic [12:0] tprod;
  logic [8:0]  recip_raw;
  logic [11:0] recip;

  assign q_eff     = (q_scale == 8'd0) ? 8'd1 : q_scale;
  // The idx-0 coefficient uses the incoming factor directly, not the stale register.
  assign scale_use = (idx_reg == 6'd0) ? q_eff : scale_reg;
  assign tprod     = {8'd0, TBL[idx_reg]} * {5'd0, scale_use};
  assign recip_raw = 9'(tprod >> 4);
  assign recip     = (recip_raw == 9'd0) ? 12'd1 : {3'd0, recip_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg   <= 6'd0;
      scale_reg <= 8'd16;
      err_reg   <= 1'b0;
    end else if (hs) begin
      idx_reg <= in_last ? 6'd0 : idx_reg + 6'd1;
      if (idx_reg == 6'd0) scale_reg <= q_eff;
      if (misalign) err_reg <= 1'b1;
    end
  end

  // ---------------- pipeline registers ----------------
  logic                 s1_valid_reg, s2_valid_reg, out_valid_reg;
  logic signed [DW-1:0] s1_data_reg;
  logic [5:0]           s1_idx_reg, s2_idx_reg, out_idx_reg;
  logic [11:0]          s1_recip_reg;
  logic signed [PW-1:0] s2_prod_reg;
  logic [OW-1:0]        out_data_reg;
  logic                 out_last_reg, out_sat_reg;

  // ---------------- S3 combinational: shift and clamp ----------------
  logic signed [RW-1:0] prod_x, res;
  logic [OW-1:0]        res_sat;
  logic                 sat;

  assign prod_x = {s2_prod_reg[PW-1], s2_prod_reg};

`ifdef QUANT_ROUND_EN
  // Round half away from zero on the magnitude, then restore the sign.
  logic [RW-1:0] mag, mag_rnd;
  assign mag     = prod_x[RW-1] ? -prod_x : prod_x;
  assign mag_rnd = (mag + (RW'(1) << (FRAC-1))) >> FRAC;
  assign res     = prod_x[RW-1] ? -$signed(mag_rnd) : $signed(mag_rnd);
`else
  assign res = prod_x >>> FRAC;
`endif

  always_comb begin
    res_sat = res[OW-1:0];
    sat     = 1'b0;
    if (res > OMAX) begin
      res_sat = {1'b0, {(OW-1){1'b1}}};
      sat     = 1'b1;
    end else if (res < OMIN) begin
      res_sat = {1'b1, {(OW-1){1'b0}}};
      sat     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_idx_reg    <= 6'd0;
      s1_recip_reg  <= 12'd0;
      s2_valid_reg  <= 1'b0;
      s2_prod_reg   <= '0;
      s2_idx_reg    <= 6'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= 6'd0;
      out_last_reg  <= 1'b0;
      out_sat_reg   <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg  <= in_valid;
      s1_data_reg   <= in_data;
      s1_idx_reg    <= idx_reg;
      s1_recip_reg  <= recip;
      s2_valid_reg  <= s1_valid_reg;
      s2_prod_reg   <= PW'(s1_data_reg) * PW'($signed({1'b0, s1_recip_reg}));
      s2_idx_reg    <= s1_idx_reg;
      out_valid_reg <= s2_valid_reg;
      out_data_reg  <= res_sat;
      out_idx_reg   <= s2_idx_reg;
      out_last_reg  <= (s2_idx_reg == 6'd63);
      out_sat_reg   <= sat;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_idx      = out_idx_reg;
  assign out_last     = out_last_reg;
  assign out_sat      = out_sat_reg;
  assign err_misalign = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_quant_stream.sv
// Testbench for quant_stream: randomized blocks against a plain-arithmetic
// reference model, scoreboard of expected outputs, directed corner cases.
`timescale 1ns/1ps

module tb_quant_stream;

  localparam int DW = 16;
  localparam int OW = 16;
  localparam int FRAC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [7:0]    q_scale = 8'd16;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [5:0]    out_idx;
  logic          out_last;
  logic          out_sat;
  logic          err_misalign;

  quant_stream #(.DW(DW), .OW(OW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .q_scale(q_scale),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int idx; bit sat; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  int blk[64];

  int tbl[64] = '{
    16, 21, 18, 18, 14, 10, 5, 3,
    23, 21, 19, 15, 11, 7, 4, 2,
    25, 18, 16, 11, 6, 4, 3, 2,
    16, 13, 10, 8, 4, 4, 2, 2,
    10, 9, 6, 5, 3, 3, 2, 2,
    6, 4, 4, 2, 2, 2, 2, 2,
    5, 4, 3, 3, 2, 2, 2, 2,
    4, 4, 4, 4, 3, 2, 2, 2
  };

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: quantize one coefficient with plain integer arithmetic.
  function automatic void model(input int d, input int idx, input int sc,
                                output int r, output bit sat);
    longint recip, p, q, div;
    div = longint'(1) << FRAC;
    recip = (longint'(tbl[idx]) * sc) / 16;
    if (recip < 1) recip = 1;
    p = longint'(d) * recip;
`ifdef QUANT_ROUND_EN
    if (p < 0) q = -((-p + div / 2) / div);
    else       q = (p + div / 2) / div;
`else
    if (p >= 0) q = p / div;
    else        q = -((-p + div - 1) / div);
`endif
    sat = 1'b0;
    if (q > 32767) begin q = 32767; sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
    r = int'(q);
  endfunction

  // out_ready pattern driver
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = !out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: model update on input handshake, scoreboard on output handshake,
  // hold check while stalled.
  initial begin : monitor
    int m_idx, m_scale, r;
    bit m_err, s, stalled_prev;
    logic [OW-1:0] p_data;
    logic [5:0] p_idx;
    logic p_valid, p_last, p_sat;
    exp_t e;
    m_idx = 0; m_scale = 16; m_err = 0; stalled_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_idx = 0; m_scale = 16; m_err = 0; stalled_prev = 0;
      end else begin
        if (stalled_prev) begin
          check("hold_valid", out_valid, p_valid);
          check("hold_data", out_data, p_data);
          check("hold_idx", out_idx, p_idx);
          check("hold_last", out_last, p_last);
          check("hold_sat", out_sat, p_sat);
        end
        check("err_misalign", err_misalign, m_err);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("out idx=%0d data=%0d sat=%0b exp_idx=%0d exp_data=%0d exp_sat=%0b",
                     out_idx, $signed(out_data), out_sat, e.idx, e.data, e.sat);
            check("out_data", longint'($signed(out_data)), e.data);
            check("out_idx", out_idx, e.idx);
            check("out_last", out_last, (e.idx == 63) ? 1 : 0);
            check("out_sat", out_sat, e.sat);
          end
        end
        if (in_valid && in_ready) begin
          if (m_idx == 0) m_scale = (q_scale == 8'd0) ? 1 : int'(q_scale);
          model(int'($signed(in_data)), m_idx, m_scale, r, s);
          e.data = r; e.idx = m_idx; e.sat = s;
          exp_q.push_back(e);
          if ((in_last && m_idx != 63) || (!in_last && m_idx == 63)) m_err = 1'b1;
          m_idx = in_last ? 0 : (m_idx + 1) % 64;
        end
        stalled_prev = out_valid && !out_ready;
        p_valid = out_valid; p_data = out_data; p_idx = out_idx;
        p_last = out_last; p_sat = out_sat;
      end
    end
  end

  // Called in the phase just after a rising edge; returns in the same phase.
  task automatic send_coef(input int d, input bit last, input int qs);
    int n;
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
    q_scale  = 8'(qs);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 3))
        0: blk[i] = int'($urandom_range(0, 600)) - 300;
        3: blk[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        default: blk[i] = int'($urandom_range(0, 65535)) - 32768;
      endcase
    end
  endtask

  task automatic send_block(input int qs, input int qs_mid, input bit with_last);
    for (int i = 0; i < 64; i++)
      send_coef(blk[i], with_last && (i == 63), (i == 0) ? qs : qs_mid);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_err", err_misalign, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int dirs[4] = '{-256, 8, -8, -7};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state();

    // Single coefficient into an empty pipe: latency, then finish the block.
    send_coef(256, 1'b0, 16);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    @(posedge clk);
    #1;
    fill_random();
    for (int i = 1; i < 64; i++) send_coef((i == 1) ? 100 : blk[i], i == 63, 16);
    drain();

    // idx-0 rounding corner values at unit scale
    foreach (dirs[k]) begin
      fill_random();
      blk[0] = dirs[k];
      send_block(16, 16, 1'b1);
    end

    // maximum reciprocal at idx16 saturates both ways; scale 0 treated as 1
    fill_random(); blk[16] = 32767;  send_block(255, 3, 1'b1);
    fill_random(); blk[16] = -32768; send_block(255, 200, 1'b1);
    fill_random(); send_block(0, 0, 1'b1);
    drain();

    // backpressure: toggled then random out_ready, q_scale changed mid-block
    rdy_mode = 1;
    for (int b = 0; b < 3; b++) begin
      fill_random();
      send_block(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    end
    rdy_mode = 2;
    for (int b = 0; b < 4; b++) begin
      fill_random();
      send_block(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    end
    drain();
    rdy_mode = 0;
    drain();

    // early in_last at idx 10 sets err and resyncs
    fill_random();
    for (int i = 0; i <= 10; i++) send_coef(blk[i], i == 10, 40);
    send_coef(1000, 1'b0, 20);
    drain();
    check("err_early_last", err_misalign, 1);
    do_reset();
    check_reset_state();

    // missing in_last at idx 63 sets err, index wraps
    fill_random();
    send_block(48, 48, 1'b0);
    send_coef(-5000, 1'b0, 32);
    drain();
    check("err_missing_last", err_misalign, 1);

    // reset with two coefficients in flight
    do_reset();
    check_reset_state();
    send_coef(1234, 1'b0, 16);
    send_coef(-4321, 1'b0, 16);
    do_reset();
    check_reset_state();
    fill_random();
    send_block(77, 5, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
